// File: rtl/radix4_divider.sv
// Sequential unsigned radix-4 restoring divider: 2 quotient bits per cycle, WIDTH/2 iterations.
// Latency: WIDTH/2 cycles from accept to out_valid (one cycle for D==0 when DIV_ZERO_EARLY_EN is defined).
// Backpressure: result holds in DONE until out_ready; in_ready only while IDLE, so ops never overlap.
module radix4_divider #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int ITERS = WIDTH / 2;
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] n_shift;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH+1:0] d3_reg;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    cnt;
    logic             dz_reg;

    logic [WIDTH+1:0] p_val;
    logic             ge1, ge2, ge3;
    logic [1:0]       q_dig;
    logic [WIDTH-1:0] qd_lo;
    logic [WIDTH-1:0] pr_nxt;
    logic             accept;

    assign in_ready  = (state == IDLE) & ~rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign quotient  = q_reg;
    assign remainder = pr;

`ifdef DIV_ZERO_EARLY_EN
    assign div_zero = dz_reg;
`else
    assign div_zero = 1'b0;
`endif

    // T_k = P - k*D is non-negative exactly when P >= k*D, so the trial
    // subtractions reduce to unsigned compares on zero-extended operands.
    always_comb begin
        p_val = {pr, n_shift[WIDTH-1 -: 2]};
        ge1   = ({1'b0, p_val} >= {3'b000, d_reg});
        ge2   = ({1'b0, p_val} >= {2'b00, d_reg, 1'b0});
        ge3   = ({1'b0, p_val} >= {1'b0, d3_reg});
        q_dig = 2'd0;
        qd_lo = '0;
        if (ge3) begin
            q_dig = 2'd3;
            qd_lo = d3_reg[WIDTH-1:0];
        end else if (ge2) begin
            q_dig = 2'd2;
            qd_lo = {d_reg[WIDTH-2:0], 1'b0};
        end else if (ge1) begin
            q_dig = 2'd1;
            qd_lo = d_reg;
        end
        // The true difference is < D, so the low WIDTH bits are exact.
        pr_nxt = p_val[WIDTH-1:0] - qd_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DIV_ZERO_EARLY_EN
                    state_nxt = (divisor == '0) ? DONE : BUSY;
`else
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                if (cnt == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_shift <= '0;
            d_reg   <= '0;
            d3_reg  <= '0;
            pr      <= '0;
            q_reg   <= '0;
            cnt     <= '0;
            dz_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        n_shift <= dividend;
                        d_reg   <= divisor;
                        d3_reg  <= {2'b00, divisor} + {1'b0, divisor, 1'b0};
                        pr      <= '0;
                        q_reg   <= '0;
                        cnt     <= '0;
`ifdef DIV_ZERO_EARLY_EN
                        if (divisor == '0) begin
                            q_reg  <= '1;
                            pr     <= dividend;
                            dz_reg <= 1'b1;
                        end
`endif
                    end
                end
                BUSY: begin
                    n_shift <= {n_shift[WIDTH-3:0], 2'b00};
                    q_reg   <= {q_reg[WIDTH-3:0], q_dig};
                    pr      <= pr_nxt;
                    cnt     <= cnt + 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        dz_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
